mc_fsm: RTL and testbench

- Multi-cycle main control FSM for the RV32I multi-cycle core variant.
- Sequences one shared ALU, one unified instruction/data memory port and the register file across FETCH/DECODE/EXECUTE/WRITEBACK steps.
- Opcode is taken from the instruction register; the immediate type stays with the existing combinational immediate decoder.
- Handles a variable-latency memory through a req/ready handshake, flags illegal opcodes and counts retired instructions.

---
 rtl/riscv_pkg.sv | 63 ++++++
 rtl/mc_ctrl_decode.sv | 90 +++++++++
 rtl/mc_fsm.sv | 125 ++++++++++++
 tb/tb_mc_fsm.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, multi-cycle FSM state encoding and
// the datapath mux select encodings driven by the control FSM.
package riscv_pkg;

   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_I      = 7'h13;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_LINK     = 4'd12,
      S_LUI      = 4'd13,
      S_TRAP     = 4'd14
   } state_t;

   localparam logic [1:0] SRC_A_PC    = 2'b00;
   localparam logic [1:0] SRC_A_OLDPC = 2'b01;
   localparam logic [1:0] SRC_A_RS1   = 2'b10;

   localparam logic [1:0] SRC_B_RS2   = 2'b00;
   localparam logic [1:0] SRC_B_IMM   = 2'b01;
   localparam logic [1:0] SRC_B_FOUR  = 2'b10;

   localparam logic [1:0] ALU_ADD     = 2'b00;
   localparam logic [1:0] ALU_SUB     = 2'b01;
   localparam logic [1:0] ALU_FUNCT   = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_MEM       = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;
   localparam logic [1:0] RES_IMM       = 2'b11;

   typedef struct packed {
      logic       mem_req;
      logic       mem_wr;
      logic       adr_src;
      logic       ir_wr;
      logic       pc_wr;
      logic       reg_wr;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] result_src;
   } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore decode of the multi-cycle FSM state into the raw control vector.
// Handshake/branch gating of write enables is applied by the caller.
module mc_ctrl_decode
   import riscv_pkg::*;
(
   input  state_t state,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_req    = 1'b1;
            ctrl.ir_wr      = 1'b1;
            ctrl.pc_wr      = 1'b1;
            ctrl.alu_src_a  = SRC_A_PC;
            ctrl.alu_src_b  = SRC_B_FOUR;
            ctrl.alu_op     = ALU_ADD;
            ctrl.result_src = RES_ALURESULT;
         end
         S_DECODE: begin
            ctrl.alu_src_a = SRC_A_OLDPC;
            ctrl.alu_src_b = SRC_B_IMM;
         end
         S_MEMADR: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_IMM;
         end
         S_MEMREAD: begin
            ctrl.mem_req = 1'b1;
            ctrl.adr_src = 1'b1;
         end
         S_MEMWB: begin
            ctrl.result_src = RES_MEM;
            ctrl.reg_wr     = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl.mem_req = 1'b1;
            ctrl.mem_wr  = 1'b1;
            ctrl.adr_src = 1'b1;
         end
         S_EXECR: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_RS2;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_EXECI: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_ALUWB: begin
            ctrl.result_src = RES_ALUOUT;
            ctrl.reg_wr     = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a  = SRC_A_RS1;
            ctrl.alu_src_b  = SRC_B_RS2;
            ctrl.alu_op     = ALU_SUB;
            ctrl.result_src = RES_ALUOUT;
            ctrl.pc_wr      = 1'b1;
         end
         S_JAL: begin
            ctrl.alu_src_a  = SRC_A_OLDPC;
            ctrl.alu_src_b  = SRC_B_FOUR;
            ctrl.result_src = RES_ALUOUT;
            ctrl.pc_wr      = 1'b1;
         end
         S_JALR: begin
            ctrl.alu_src_a  = SRC_A_RS1;
            ctrl.alu_src_b  = SRC_B_IMM;
            ctrl.result_src = RES_ALURESULT;
            ctrl.pc_wr      = 1'b1;
         end
         S_LINK: begin
            ctrl.alu_src_a  = SRC_A_OLDPC;
            ctrl.alu_src_b  = SRC_B_FOUR;
            ctrl.result_src = RES_ALURESULT;
            ctrl.reg_wr     = 1'b1;
         end
         S_LUI: begin
            ctrl.result_src = RES_IMM;
            ctrl.reg_wr     = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mc_fsm.sv
// Multi-cycle RV32I main control FSM: state register, next-state logic,
// handshake gating of write enables, sticky trap flag and retire counter.
module mc_fsm
   import riscv_pkg::*;
#(
   parameter int unsigned P_CNT_W = 32
) (
   input  logic               iclk,
   input  logic               irst_n,
   input  logic [6:0]         iop,
   input  logic               imem_ready,
   input  logic               ibr_taken,
   output logic               omem_req,
   output logic               omem_wr,
   output logic               oadr_src,
   output logic               oir_wr,
   output logic               opc_wr,
   output logic               oreg_wr,
   output logic [1:0]         oalu_src_a,
   output logic [1:0]         oalu_src_b,
   output logic [1:0]         oalu_op,
   output logic [1:0]         oresult_src,
   output logic               otrap,
   output logic [P_CNT_W-1:0] oinstret
);

   state_t              state, state_nxt;
   ctrl_t               raw;
   logic                trap_q;
   logic [P_CNT_W-1:0]  instret_q;
   logic                retire;
   logic                pc_gate;

   mc_ctrl_decode u_decode (
      .state (state),
      .ctrl  (raw)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:    if (imem_ready) state_nxt = S_DECODE;
         S_DECODE: begin
            case (iop)
               OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
               OP_R:              state_nxt = S_EXECR;
               OP_I:              state_nxt = S_EXECI;
               OP_BRANCH:         state_nxt = S_BRANCH;
               OP_JAL:            state_nxt = S_JAL;
               OP_JALR:           state_nxt = S_JALR;
               OP_LUI:            state_nxt = S_LUI;
               OP_AUIPC:          state_nxt = S_ALUWB;
               default:           state_nxt = S_TRAP;
            endcase
         end
         S_MEMADR:   state_nxt = (iop == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (imem_ready) state_nxt = S_MEMWB;
         S_MEMWB:    state_nxt = S_FETCH;
         S_MEMWRITE: if (imem_ready) state_nxt = S_FETCH;
         S_EXECR:    state_nxt = S_ALUWB;
         S_EXECI:    state_nxt = S_ALUWB;
         S_ALUWB:    state_nxt = S_FETCH;
         S_BRANCH:   state_nxt = S_FETCH;
         S_JAL:      state_nxt = S_ALUWB;
         S_JALR:     state_nxt = S_LINK;
         S_LINK:     state_nxt = S_FETCH;
         S_LUI:      state_nxt = S_FETCH;
         S_TRAP:     state_nxt = S_TRAP;
         default:    state_nxt = S_FETCH;
      endcase
   end

   assign retire = (state_nxt == S_FETCH) && (state != S_FETCH);

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state     <= S_FETCH;
         trap_q    <= 1'b0;
         instret_q <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt == S_TRAP) trap_q <= 1'b1;
         if (retire) instret_q <= instret_q + 1'b1;
      end
   end

   // PC write in FETCH waits for the fetch to land; in BRANCH it follows the compare
   always_comb begin
      case (state)
         S_FETCH:  pc_gate = imem_ready;
         S_BRANCH: pc_gate = ibr_taken;
         default:  pc_gate = 1'b1;
      endcase
   end

   // Controls are held low for the whole reset interval, not only after the first edge
   always_comb begin
      omem_req    = 1'b0;
      omem_wr     = 1'b0;
      oadr_src    = 1'b0;
      oir_wr      = 1'b0;
      opc_wr      = 1'b0;
      oreg_wr     = 1'b0;
      oalu_src_a  = '0;
      oalu_src_b  = '0;
      oalu_op     = '0;
      oresult_src = '0;
      if (irst_n) begin
         omem_req    = raw.mem_req;
         omem_wr     = raw.mem_wr;
         oadr_src    = raw.adr_src;
         oir_wr      = raw.ir_wr & imem_ready;
         opc_wr      = raw.pc_wr & pc_gate;
         oreg_wr     = raw.reg_wr;
         oalu_src_a  = raw.alu_src_a;
         oalu_src_b  = raw.alu_src_b;
         oalu_op     = raw.alu_op;
         oresult_src = raw.result_src;
      end
   end

   assign otrap    = trap_q;
   assign oinstret = instret_q;

endmodule

// File: tb/tb_mc_fsm.sv
// Self-checking bench for mc_fsm: instruction-level model expands each
// instruction into its expected per-cycle control sequence.
module tb_mc_fsm;

   logic       iclk;
   logic       irst_n;
   logic [6:0] iop;
   logic       imem_ready;
   logic       ibr_taken;

   logic        mem_req, mem_wr, adr_src, ir_wr, pc_wr, reg_wr, trap;
   logic [1:0]  src_a, src_b, alu_op, res_src;
   logic [31:0] instret;

   logic        mem_req4, mem_wr4, adr_src4, ir_wr4, pc_wr4, reg_wr4, trap4;
   logic [1:0]  src_a4, src_b4, alu_op4, res_src4;
   logic [3:0]  instret4;

   mc_fsm #(.P_CNT_W(32)) dut (
      .iclk(iclk), .irst_n(irst_n), .iop(iop), .imem_ready(imem_ready),
      .ibr_taken(ibr_taken), .omem_req(mem_req), .omem_wr(mem_wr),
      .oadr_src(adr_src), .oir_wr(ir_wr), .opc_wr(pc_wr), .oreg_wr(reg_wr),
      .oalu_src_a(src_a), .oalu_src_b(src_b), .oalu_op(alu_op),
      .oresult_src(res_src), .otrap(trap), .oinstret(instret)
   );

   mc_fsm #(.P_CNT_W(4)) dut4 (
      .iclk(iclk), .irst_n(irst_n), .iop(iop), .imem_ready(imem_ready),
      .ibr_taken(ibr_taken), .omem_req(mem_req4), .omem_wr(mem_wr4),
      .oadr_src(adr_src4), .oir_wr(ir_wr4), .opc_wr(pc_wr4), .oreg_wr(reg_wr4),
      .oalu_src_a(src_a4), .oalu_src_b(src_b4), .oalu_op(alu_op4),
      .oresult_src(res_src4), .otrap(trap4), .oinstret(instret4)
   );

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   typedef struct {
      logic        rdy;
      logic        br;
      logic [6:0]  op;
      logic [14:0] exp;
      bit          retire;
   } step_t;

   step_t       q[$];
   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned model_cnt = 0;

   wire [14:0] act  = {mem_req, mem_wr, adr_src, ir_wr, pc_wr, reg_wr,
                       src_a, src_b, alu_op, res_src, trap};
   wire [14:0] act4 = {mem_req4, mem_wr4, adr_src4, ir_wr4, pc_wr4, reg_wr4,
                       src_a4, src_b4, alu_op4, res_src4, trap4};

   function automatic logic [14:0] mk(input logic req, input logic wr,
      input logic adr, input logic ir, input logic pc, input logic rw,
      input logic [1:0] a, input logic [1:0] b, input logic [1:0] o,
      input logic [1:0] r, input logic t);
      return {req, wr, adr, ir, pc, rw, a, b, o, r, t};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic push(input logic rdy, input logic br, input logic [6:0] op,
                       input logic [14:0] e, input bit ret);
      step_t s;
      s.rdy = rdy; s.br = br; s.op = op; s.exp = e; s.retire = ret;
      q.push_back(s);
   endtask

   // Expected cycle sequence of one instruction, written from the control table
   task automatic add_instr(input logic [6:0] op, input int unsigned fwait,
                            input int unsigned mwait, input logic br,
                            input int unsigned trapcyc);
      logic [14:0] aluwb;
      logic        st;
      aluwb = mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0);
      st    = (op == 7'h23);
      for (int unsigned i = 0; i < fwait; i++)
         push(0, 0, op, mk(1,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0), 0);
      push(1, 0, op, mk(1,0,0,1,1,0, 2'b00,2'b10,2'b00,2'b10, 0), 0);
      push(1, 0, op, mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0), 0);
      case (op)
         7'h03, 7'h23: begin
            push(1, 0, op, mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0), 0);
            for (int unsigned i = 0; i < mwait; i++)
               push(0, 0, op, mk(1,st,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0), 0);
            push(1, 0, op, mk(1,st,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0), st);
            if (!st) push(1, 0, op, mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b01, 0), 1);
         end
         7'h33: begin
            push(1, 0, op, mk(0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 0), 0);
            push(1, 0, op, aluwb, 1);
         end
         7'h13: begin
            push(1, 0, op, mk(0,0,0,0,0,0, 2'b10,2'b01,2'b10,2'b00, 0), 0);
            push(1, 0, op, aluwb, 1);
         end
         7'h63: push(1, br, op, mk(0,0,0,0,br,0, 2'b10,2'b00,2'b01,2'b00, 0), 1);
         7'h6F: begin
            push(1, 0, op, mk(0,0,0,0,1,0, 2'b01,2'b10,2'b00,2'b00, 0), 0);
            push(1, 0, op, aluwb, 1);
         end
         7'h67: begin
            push(1, 0, op, mk(0,0,0,0,1,0, 2'b10,2'b01,2'b00,2'b10, 0), 0);
            push(1, 0, op, mk(0,0,0,0,0,1, 2'b01,2'b10,2'b00,2'b10, 0), 1);
         end
         7'h37: push(1, 0, op, mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b11, 0), 1);
         7'h17: push(1, 0, op, aluwb, 1);
         default:
            for (int unsigned i = 0; i < trapcyc; i++)
               push(logic'(i % 2), logic'((i / 2) % 2), op, '0 | 15'd1, 0);
      endcase
   endtask

   task automatic run_queue();
      step_t s;
      while (q.size() != 0) begin
         s = q.pop_front();
         imem_ready = s.rdy;
         ibr_taken  = s.br;
         iop        = s.op;
         #1;
         check("ctrl",     {17'd0, act},  {17'd0, s.exp});
         check("ctrl_w4",  {17'd0, act4}, {17'd0, s.exp});
         check("instret",  instret,  model_cnt);
         check("instret4", {28'd0, instret4}, model_cnt % 16);
         if (s.retire) model_cnt++;
         @(negedge iclk);
      end
   endtask

   function automatic int unsigned count_field(input int unsigned bitpos);
      int unsigned n = 0;
      foreach (q[i]) if (q[i].exp[bitpos]) n++;
      return n;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      irst_n = 1'b0; iop = 7'h00; imem_ready = 1'b1; ibr_taken = 1'b1;
      repeat (2) @(negedge iclk);
      #1;
      check("reset_ctrl", {17'd0, act}, 32'd0);
      check("reset_instret", instret, 32'd0);
      @(negedge iclk);
      irst_n = 1'b1;

      add_instr(7'h33, 0, 0, 0, 0);
      check("model_rtype_len", q.size(), 32'd4);
      run_queue();
      check("rtype_instret", instret, 32'd1);

      add_instr(7'h03, 3, 3, 0, 0);
      check("model_load_len", q.size(), 32'd12 - 32'd1);
      check("model_load_irwr", count_field(11), 32'd1);
      check("model_load_req", count_field(14), 32'd8);
      run_queue();

      add_instr(7'h63, 0, 0, 0, 0);
      add_instr(7'h63, 1, 0, 1, 0);
      run_queue();
      check("branch_instret", instret, 32'd4);

      add_instr(7'h67, 0, 0, 0, 0);
      run_queue();
      check("jalr_instret", instret, 32'd5);

      add_instr(7'h23, 2, 2, 0, 0);
      add_instr(7'h13, 0, 0, 0, 0);
      add_instr(7'h6F, 1, 0, 0, 0);
      add_instr(7'h37, 0, 0, 0, 0);
      add_instr(7'h17, 0, 0, 0, 0);
      run_queue();
      check("mix_instret", instret, 32'd10);

      add_instr(7'h7F, 0, 0, 0, 20);
      run_queue();
      check("trap_flag", {31'd0, trap}, 32'd1);
      check("trap_instret", instret, 32'd10);

      // Asynchronous reset in the middle of a cycle, away from both clock edges
      #3;
      irst_n = 1'b0;
      #1;
      check("midreset_ctrl", {17'd0, act}, 32'd0);
      check("midreset_trap", {31'd0, trap}, 32'd0);
      check("midreset_instret", instret, 32'd0);
      check("midreset_instret4", {28'd0, instret4}, 32'd0);
      model_cnt = 0;
      @(negedge iclk);
      irst_n = 1'b1;

      for (int i = 0; i < 17; i++) add_instr(7'h13, 0, 0, 0, 0);
      run_queue();
      check("wrap_instret4", {28'd0, instret4}, 32'd1);
      check("wrap_instret", instret, 32'd17);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
